// File: rtl/game_ctrl_if.sv
// Signal bundle between the match sequencer and the puck datapath / VGA overlay.
// Event semantics: inputs are level signals sampled on clk; rising edges form the events.
interface game_ctrl_if;
  logic       prev_clk_cursor;
  logic       clk_cursor;
  logic       btn_start;
  logic       collide1;
  logic       collide2;
  logic       puck_clr;
  logic [3:0] score1;
  logic [3:0] score2;
  logic       game_over;
  logic       winner;
  logic [2:0] state;

  modport master (
    output prev_clk_cursor, clk_cursor, btn_start, collide1, collide2,
    input  puck_clr, score1, score2, game_over, winner, state
  );

  modport slave (
    input  prev_clk_cursor, clk_cursor, btn_start, collide1, collide2,
    output puck_clr, score1, score2, game_over, winner, state
  );
endinterface

// File: rtl/game_ctrl.sv
// Air-hockey match sequencer: IDLE -> SERVE -> PLAY -> GOAL -> OVER, scores and winner.
// All outputs are registered; the FSM state is exported on bus.state.
module game_ctrl #(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_TICKS = 30,
  parameter int GOAL_TICKS  = 60
) (
  input logic        clk,
  input logic        clr_n,
  game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    GOAL  = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [3:0] WIN_LIM   = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LIM = 8'(SERVE_TICKS);
  localparam logic [7:0] GOAL_LIM  = 8'(GOAL_TICKS);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] score1_q, score1_d;
  logic [3:0] score2_q, score2_d;
  logic       winner_q, winner_d;
  logic       puck_clr_q, game_over_q;

  logic start_s1, start_s2, start_s3;
  logic c1_q, c2_q;
  logic tick, start_ev, goal1_ev, goal2_ev, can_score;

  assign tick      = ~bus.prev_clk_cursor & bus.clk_cursor;
  assign start_ev  = start_s2 & ~start_s3;
  assign goal1_ev  = bus.collide1 & ~c1_q;
  assign goal2_ev  = bus.collide2 & ~c2_q;
  assign can_score = (score1_q < WIN_LIM) && (score2_q < WIN_LIM);

  // btn_start is asynchronous: two flops of synchronisation, a third for the edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_s3 <= 1'b0;
      c1_q     <= 1'b0;
      c2_q     <= 1'b0;
    end else begin
      start_s1 <= bus.btn_start;
      start_s2 <= start_s1;
      start_s3 <= start_s2;
      c1_q     <= bus.collide1;
      c2_q     <= bus.collide2;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    score1_d = score1_q;
    score2_d = score2_q;
    winner_d = winner_q;
    case (state_q)
      IDLE: begin
        if (start_ev) begin
          score1_d = 4'd0;
          score2_d = 4'd0;
          cnt_d    = 8'd0;
          state_d  = SERVE;
        end
      end
      SERVE: begin
        if (tick) begin
          if (cnt_q + 8'd1 == SERVE_LIM) begin
            cnt_d   = 8'd0;
            state_d = PLAY;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      PLAY: begin
        // goal1 (left goal, point to player 2) has priority on a simultaneous hit
        if (goal1_ev) begin
          if (can_score) score2_d = score2_q + 4'd1;
          cnt_d   = 8'd0;
          state_d = GOAL;
        end else if (goal2_ev) begin
          if (can_score) score1_d = score1_q + 4'd1;
          cnt_d   = 8'd0;
          state_d = GOAL;
        end
      end
      GOAL: begin
        if (tick) begin
          if (cnt_q + 8'd1 == GOAL_LIM) begin
            cnt_d = 8'd0;
            if (score1_q == WIN_LIM || score2_q == WIN_LIM) begin
              state_d  = OVER;
              winner_d = (score2_q == WIN_LIM);
            end else begin
              state_d = SERVE;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      OVER: begin
        if (start_ev) begin
          score1_d = 4'd0;
          score2_d = 4'd0;
          cnt_d    = 8'd0;
          state_d  = SERVE;
        end
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = IDLE;
      end
    endcase
  end

  // puck_clr and game_over follow the next state so they change on the transition edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      score1_q    <= 4'd0;
      score2_q    <= 4'd0;
      winner_q    <= 1'b0;
      puck_clr_q  <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      winner_q    <= winner_d;
      puck_clr_q  <= (state_d == IDLE) || (state_d == SERVE) || (state_d == OVER);
      game_over_q <= (state_d == OVER);
    end
  end

  assign bus.state     = state_q;
  assign bus.score1    = score1_q;
  assign bus.score2    = score2_q;
  assign bus.winner    = winner_q;
  assign bus.puck_clr  = puck_clr_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed match scenarios plus randomized play, checked every
// cycle against a behavioural match model and a set of literal expectations.
module tb_game_ctrl;

  localparam int WIN = 2;
  localparam int ST  = 3;
  localparam int GT  = 2;

  localparam int P_IDLE  = 0;
  localparam int P_SERVE = 1;
  localparam int P_PLAY  = 2;
  localparam int P_GOAL  = 3;
  localparam int P_OVER  = 4;

  logic clk;
  logic clr_n;
  game_ctrl_if bus();

  game_ctrl #(.WIN_SCORE(WIN), .SERVE_TICKS(ST), .GOAL_TICKS(GT)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // motion clock: regular 4-clk period, or random levels when rand_tick is set
  int tp = 0;
  bit rand_tick = 1'b0;
  always @(negedge clk) begin
    bus.prev_clk_cursor = bus.clk_cursor;
    if (rand_tick) bus.clk_cursor = 1'($urandom_range(0, 1));
    else begin
      tp = (tp + 1) % 4;
      bus.clk_cursor = (tp >= 2);
    end
  end

  // behavioural match model
  int   m_phase, m_cnt, m_s1, m_s2;
  bit   m_win;
  bit   m_c1_last, m_c2_last;
  bit [2:0] m_btn_hist;
  int   tick_total = 0;
  logic [13:0] exp_q[$];

  function automatic logic [13:0] m_pack();
    logic pc;
    pc = (m_phase == P_IDLE) || (m_phase == P_SERVE) || (m_phase == P_OVER);
    return {pc, 4'(m_s1), 4'(m_s2), (m_phase == P_OVER), m_win, 3'(m_phase)};
  endfunction

  always @(posedge clk or negedge clr_n) begin
    bit tk, g1, g2, st;
    if (!clr_n) begin
      m_phase = P_IDLE; m_cnt = 0; m_s1 = 0; m_s2 = 0; m_win = 1'b0;
      m_c1_last = 1'b0; m_c2_last = 1'b0; m_btn_hist = 3'b000;
      exp_q.delete();
    end else begin
      tk = !bus.prev_clk_cursor && bus.clk_cursor;
      g1 = bus.collide1 && !m_c1_last;
      g2 = bus.collide2 && !m_c2_last;
      st = m_btn_hist[1] && !m_btn_hist[2];
      if (tk) tick_total++;
      if ((m_phase == P_IDLE || m_phase == P_OVER) && st) begin
        m_s1 = 0; m_s2 = 0; m_cnt = 0; m_phase = P_SERVE;
      end else if (m_phase == P_SERVE && tk) begin
        m_cnt++;
        if (m_cnt == ST) begin m_cnt = 0; m_phase = P_PLAY; end
      end else if (m_phase == P_PLAY && (g1 || g2)) begin
        if (m_s1 < WIN && m_s2 < WIN) begin
          if (g1) m_s2++; else m_s1++;
        end
        m_cnt = 0; m_phase = P_GOAL;
      end else if (m_phase == P_GOAL && tk) begin
        m_cnt++;
        if (m_cnt == GT) begin
          m_cnt = 0;
          if (m_s1 == WIN || m_s2 == WIN) begin
            m_phase = P_OVER; m_win = (m_s2 == WIN);
          end else m_phase = P_SERVE;
        end
      end
      m_c1_last = bus.collide1;
      m_c2_last = bus.collide2;
      m_btn_hist = {m_btn_hist[1:0], bus.btn_start};
      exp_q.push_back(m_pack());
    end
  end

  // scoreboard: one expected word per clk, compared away from the active edge
  always @(negedge clk) begin
    logic [13:0] e, a;
    if (clr_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.puck_clr, bus.score1, bus.score2, bus.game_over, bus.winner, bus.state};
      if (!e[4]) begin e[3] = 1'b0; a[3] = 1'b0; end
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL cycle_model t=%0t got=%h expected=%h", $time, a, e);
      end
    end
  end

  // driver tasks
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (bus.state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 16'(bus.state), 16'(s));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 16'(bus.state), 16'd0);
    check({tag, "_score1"}, 16'(bus.score1), 16'd0);
    check({tag, "_score2"}, 16'(bus.score2), 16'd0);
    check({tag, "_puck_clr"}, 16'(bus.puck_clr), 16'd1);
    check({tag, "_game_over"}, 16'(bus.game_over), 16'd0);
    check({tag, "_winner"}, 16'(bus.winner), 16'd0);
  endtask

  initial begin
    int t0;
    bus.btn_start = 1'b0; bus.collide1 = 1'b0; bus.collide2 = 1'b0;
    bus.prev_clk_cursor = 1'b0; bus.clk_cursor = 1'b0;
    clr_n = 1'b1;
    #1 clr_n = 1'b0;
    wait_clk(3);
    check_reset_values("reset");
    clr_n = 1'b1;
    wait_clk(4);
    check("idle_hold", 16'(bus.state), 16'd0);

    // serve: exactly SERVE_TICKS ticks with the puck held, then play
    bus.btn_start = 1'b1;
    wait_clk(3);
    bus.btn_start = 1'b0;
    wait_state(3'd1, 20, "enter_serve");
    t0 = tick_total;
    check("serve_puck_clr", 16'(bus.puck_clr), 16'd1);
    wait_state(3'd2, 40, "enter_play");
    check("serve_ticks", 16'(tick_total - t0), 16'd3);
    check("play_puck_clr", 16'(bus.puck_clr), 16'd0);

    // long collide2 hold gives a single point to player 1
    bus.collide2 = 1'b1;
    wait_clk(2);
    check("goal2_state", 16'(bus.state), 16'd3);
    check("goal2_score1", 16'(bus.score1), 16'd1);
    wait_clk(6);
    bus.collide2 = 1'b0;
    check("goal2_single", 16'(bus.score1), 16'd1);
    wait_state(3'd1, 40, "goal_to_serve");
    check("reserve_puck_clr", 16'(bus.puck_clr), 16'd1);

    // simultaneous goals: left goal wins
    wait_state(3'd2, 60, "replay");
    bus.collide1 = 1'b1; bus.collide2 = 1'b1;
    wait_clk(2);
    check("both_score2", 16'(bus.score2), 16'd1);
    check("both_score1", 16'(bus.score1), 16'd1);
    check("both_state", 16'(bus.state), 16'd3);
    bus.collide1 = 1'b0; bus.collide2 = 1'b0;

    // player 2 reaches WIN_SCORE
    wait_state(3'd1, 40, "serve3");
    wait_state(3'd2, 60, "play3");
    bus.collide1 = 1'b1;
    wait_clk(2);
    bus.collide1 = 1'b0;
    check("win_score2", 16'(bus.score2), 16'd2);
    wait_state(3'd4, 40, "enter_over");
    check("over_game_over", 16'(bus.game_over), 16'd1);
    check("over_winner", 16'(bus.winner), 16'd1);
    check("over_puck_clr", 16'(bus.puck_clr), 16'd1);
    for (int i = 0; i < 3; i++) begin
      bus.collide1 = 1'b1; wait_clk(2); bus.collide1 = 1'b0; wait_clk(2);
      bus.collide2 = 1'b1; wait_clk(2); bus.collide2 = 1'b0; wait_clk(2);
    end
    check("over_score1", 16'(bus.score1), 16'd1);
    check("over_score2", 16'(bus.score2), 16'd2);
    check("over_hold", 16'(bus.state), 16'd4);

    // rematch from a long start press
    bus.btn_start = 1'b1;
    wait_clk(6);
    check("rematch_state", 16'(bus.state), 16'd1);
    check("rematch_score1", 16'(bus.score1), 16'd0);
    check("rematch_score2", 16'(bus.score2), 16'd0);
    check("rematch_game_over", 16'(bus.game_over), 16'd0);
    wait_clk(4);
    bus.btn_start = 1'b0;

    // asynchronous reset mid-GOAL
    wait_state(3'd2, 60, "play_pre_reset");
    bus.collide2 = 1'b1;
    wait_clk(2);
    bus.collide2 = 1'b0;
    check("pre_reset_state", 16'(bus.state), 16'd3);
    check("pre_reset_score1", 16'(bus.score1), 16'd1);
    @(posedge clk);
    #2 clr_n = 1'b0;
    #1 check_reset_values("async_reset");
    wait_clk(3);
    clr_n = 1'b1;
    wait_clk(10);
    check("post_reset_idle", 16'(bus.state), 16'd0);

    // randomized play; the per-cycle model comparison does the checking
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rand_tick = ((i / 1000) % 2) == 1;
      if ($urandom_range(0, 29) == 0) bus.btn_start = ~bus.btn_start;
      if ($urandom_range(0, 14) == 0) bus.collide1 = ~bus.collide1;
      if ($urandom_range(0, 14) == 0) bus.collide2 = ~bus.collide2;
      if (i == 1500 || i == 3100) begin
        @(posedge clk);
        #3 clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
      end
    end
    wait_clk(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Match sequencer for the air-hockey puck datapath. Owns the puck mover's clear line and tracks the puck-motion tick. Takes the mover's goal flags (collide1/collide2) and the start button, and runs the IDLE -> SERVE -> PLAY -> GOAL -> OVER flow. Keeps per-player scores for the VGA overlay and declares the winner.

Parameters:
WIN_SCORE, 7, points needed to win (1..15).
SERVE_TICKS, 30, motion ticks the puck is held at centre before launch (1..255).
GOAL_TICKS, 60, motion ticks of freeze after a goal (1..255).

Ports:
clk  in  1  system clock (same clock as the mover).
clr_n  in  1  asynchronous active-low reset.
prev_clk_cursor  in  1  registered previous level of the motion clock.
clk_cursor  in  1  motion clock level; tick = ~prev_clk_cursor & clk_cursor.
btn_start  in  1  raw start button, asynchronous to clk.
collide1  in  1  mover flag: puck in the left goal; a point for player 2.
collide2  in  1  mover flag: puck in the right goal; a point for player 1.
puck_clr  out  1  drives the mover's clr (active high); centres the puck and reloads its launch velocity.
score1  out  4  player 1 score.
score2  out  4  player 2 score.
game_over  out  1  high in OVER.
winner  out  1  0 = player 1, 1 = player 2; valid when game_over = 1.
state  out  3  encoding: IDLE = 0, SERVE = 1, PLAY = 2, GOAL = 3, OVER = 4.

Behaviour:
- Reset (clr_n low, asynchronous):
  - state = IDLE; score1 = score2 = 0; puck_clr = 1; game_over = 0; winner = 0.
  - Tick counter = 0; internal sync and edge registers = 0.
  - Reset asserted mid-game aborts immediately. There is no partial-score retention.
- Start input:
  - btn_start passes through a 2-flop synchroniser.
  - start_ev = synchronised level rising (1 clk pulse).
- Goal input:
  - collide1/collide2 are registered once (c1_q, c2_q).
  - goal1_ev = collide1 & ~c1_q; goal2_ev likewise.
  - Rising-edge detection gives exactly one event per goal, although the mover holds the flag for a whole motion period.
- All outputs are registered. State, score and counter updates take effect on the clk edge where the qualifying event is high. They are visible 1 clk later.
- IDLE:
  - puck_clr = 1.
  - start_ev -> clear both scores, counter = 0, go to SERVE.
- SERVE:
  - puck_clr = 1.
  - Counter increments on each tick.
  - On the tick that makes counter = SERVE_TICKS: counter = 0, go to PLAY. puck_clr drops on that same edge.
  - Goal events are ignored.
- PLAY:
  - puck_clr = 0.
  - goal2_ev -> score1 + 1, go to GOAL.
  - goal1_ev -> score2 + 1, go to GOAL.
  - If both events fire on the same cycle, goal1_ev wins: score2 increments only.
  - start_ev is ignored.
- GOAL:
  - puck_clr = 0; the mover has already parked the puck with zero velocity.
  - Counter counts ticks to GOAL_TICKS, then counter = 0.
  - At that point: if score1 == WIN_SCORE or score2 == WIN_SCORE, go to OVER; otherwise go to SERVE.
  - Further goal events are ignored.
- OVER:
  - puck_clr = 1; game_over = 1.
  - winner is latched on entry: 1 if score2 == WIN_SCORE, else 0.
  - start_ev -> clear scores, game_over = 0, go to SERVE (rematch).
- Scores:
  - 4-bit unsigned.
  - An increment can only occur in PLAY while both scores are < WIN_SCORE, so scores never exceed WIN_SCORE and never wrap.
- Counter:
  - 8-bit; holds between ticks.
  - Cleared on every state transition.
- tick and a goal event on the same cycle in PLAY: the goal is taken and the counter is cleared.
- Undefined state encodings recover to IDLE.

Test Plan:
All scenarios use WIN_SCORE = 2, SERVE_TICKS = 3, GOAL_TICKS = 2, and one tick every 4 clk.
1. Reset, then start pulse -> state IDLE -> SERVE. puck_clr stays 1 for exactly 3 ticks, then state = 2 and puck_clr = 0 one clk after the 3rd tick.
2. In PLAY, collide2 held high for 8 clk -> score1 = 1 (a single increment) and state = 3. After 2 ticks, state = 1 with puck_clr = 1.
3. collide1 and collide2 rise on the same clk in PLAY -> score2 = 1, score1 unchanged.
4. Drive player 2 to two goals -> after the 2nd GOAL freeze: state = 4, game_over = 1, winner = 1, puck_clr = 1. Further collide pulses leave scores at 0/2.
5. In OVER, a start pulse (btn_start async, held 10 clk) -> one start_ev only: scores 0/0, game_over = 0, state = 1.
6. Assert clr_n low mid-GOAL with score1 = 1, asynchronously between clk edges -> outputs go to reset values immediately. After release, state = 0 until start.
